// File: rtl/imem_refill_arbiter.sv
// imem_refill_arbiter: shares one external memory read port between the
// instruction-cache and data-side miss handlers. Round-robin grant, one
// line-aligned read per grant, response beats replayed as addressed fills.
//
// Handshake semantics: a memory request transfers in the cycle where
// mem_req_valid && mem_req_ready are both high; mem_req_valid and
// mem_req_addr stay stable until then. Miss requesters hold *_miss_valid
// high until the single-cycle *_miss_ack pulse; fill outputs are
// single-cycle valid pulses with no backpressure.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module imem_refill_arbiter #(
  parameter int ADDR_W     = `ADDR_WIDTH,
  parameter int LINE_BEATS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ext_flush,
  input  logic              i_miss_valid,
  input  logic [ADDR_W-1:0] i_miss_addr,
  output logic              i_miss_ack,
  input  logic              d_miss_valid,
  input  logic [ADDR_W-1:0] d_miss_addr,
  output logic              d_miss_ack,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [63:0]       mem_resp_data,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_addr_valid,
  output logic [63:0]       fetched_data,
  output logic [ADDR_W-1:0] d_fill_addr,
  output logic              d_fill_valid,
  output logic [63:0]       d_fill_data,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(LINE_BEATS);
  localparam int OFF_W = $clog2(LINE_BEATS * 8);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t             state, state_next;
  logic               grant_i, grant_d;
  logic               ptr_last_d;   // 1: last grant went to D
  logic               owner_d;      // 1: D owns the current transaction
  logic               drop;         // I transaction flushed, suppress fills
  logic [CNT_W-1:0]   beat_cnt;
  logic [ADDR_W-1:0]  base_addr;
  logic               beat_fire;
  logic [ADDR_W-1:0]  beat_addr;

  assign beat_fire = (state == S_DATA) && mem_resp_valid;
  assign beat_addr = base_addr + (ADDR_W'(beat_cnt) << 3);

  // Next-state and arbitration; grants only happen in IDLE.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      S_IDLE: begin
        grant_i = (i_miss_valid && !ext_flush) && (!d_miss_valid || ptr_last_d);
        grant_d = d_miss_valid && (!(i_miss_valid && !ext_flush) || !ptr_last_d);
        if (grant_i || grant_d) state_next = S_REQ;
      end
      S_REQ: begin
        if (mem_req_ready) state_next = S_DATA;
      end
      S_DATA: begin
        if (mem_resp_valid && (beat_cnt == LAST_BEAT)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Acks are masked while reset is asserted so every output is 0 in reset.
  assign i_miss_ack    = grant_i && reset;
  assign d_miss_ack    = grant_d && reset;
  assign mem_req_valid = (state == S_REQ);
  assign mem_req_addr  = base_addr;
  assign busy          = (state != S_IDLE);
  assign state_dbg     = state;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Transaction context: owner, base, beat counter, drop flag, RR pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_last_d <= 1'b1;
      owner_d    <= 1'b0;
      base_addr  <= '0;
      beat_cnt   <= '0;
      drop       <= 1'b0;
    end else if (grant_i || grant_d) begin
      ptr_last_d <= grant_d;
      owner_d    <= grant_d;
      base_addr  <= (grant_d ? d_miss_addr : i_miss_addr) & LINE_MASK;
      beat_cnt   <= '0;
      drop       <= 1'b0;
    end else if (state != S_IDLE) begin
      if (!owner_d && ext_flush) drop <= 1'b1;
      if (beat_fire) beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Registered fill replay; address/data only move on a delivered beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_addr_valid <= 1'b0;
      fetch_addr       <= '0;
      fetched_data     <= '0;
      d_fill_valid     <= 1'b0;
      d_fill_addr      <= '0;
      d_fill_data      <= '0;
    end else begin
      fetch_addr_valid <= beat_fire && !owner_d && !drop && !ext_flush;
      d_fill_valid     <= beat_fire && owner_d;
      if (beat_fire && !owner_d && !drop && !ext_flush) begin
        fetch_addr   <= beat_addr;
        fetched_data <= mem_resp_data;
      end
      if (beat_fire && owner_d) begin
        d_fill_addr <= beat_addr;
        d_fill_data <= mem_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_imem_refill_arbiter.sv
// Directed, table-driven bench for imem_refill_arbiter (ADDR_W=32,
// LINE_BEATS=4). Each vector is one clock cycle: inputs are driven on the
// falling edge and every output is compared 1 time unit later.

`timescale 1ns/1ps

module tb_imem_refill_arbiter;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic        fl;
    logic        rdy;
    logic        rv;
    logic [63:0] rd;
    logic        ai;
    logic        ad;
    logic        rqv;
    logic [31:0] ra;
    logic        fiv;
    logic        fdv;
    logic [31:0] fa;
    logic [63:0] fdat;
    logic        bz;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        ext_flush;
  logic        i_miss_valid;
  logic [31:0] i_miss_addr;
  logic        i_miss_ack;
  logic        d_miss_valid;
  logic [31:0] d_miss_addr;
  logic        d_miss_ack;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic [31:0] fetch_addr;
  logic        fetch_addr_valid;
  logic [63:0] fetched_data;
  logic [31:0] d_fill_addr;
  logic        d_fill_valid;
  logic [63:0] d_fill_data;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // Expected held values of the fill address/data outputs.
  logic [31:0] hi_a, hd_a;
  logic [63:0] hi_d, hd_d;

  // Generator bookkeeping for the back-to-back round-robin section.
  logic [31:0] last_base;
  logic        tail_i, tail_d;
  logic [31:0] tail_a;
  logic [63:0] tail_dat;

  vec_t tbl[$];

  imem_refill_arbiter #(.ADDR_W(32), .LINE_BEATS(4)) dut (
    .clk(clk), .reset(reset), .ext_flush(ext_flush),
    .i_miss_valid(i_miss_valid), .i_miss_addr(i_miss_addr), .i_miss_ack(i_miss_ack),
    .d_miss_valid(d_miss_valid), .d_miss_addr(d_miss_addr), .d_miss_ack(d_miss_ack),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .fetch_addr(fetch_addr), .fetch_addr_valid(fetch_addr_valid), .fetched_data(fetched_data),
    .d_fill_addr(d_fill_addr), .d_fill_valid(d_fill_valid), .d_fill_data(d_fill_data),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(logic iv, logic [31:0] ia, logic dv, logic [31:0] da,
                             logic fl, logic rdy, logic rv, logic [63:0] rd,
                             logic ai, logic ad, logic rqv, logic [31:0] ra,
                             logic fiv, logic fdv, logic [31:0] fa, logic [63:0] fdat,
                             logic bz);
    vec_t x;
    x.rst = 1'b1; x.iv = iv; x.ia = ia; x.dv = dv; x.da = da; x.fl = fl;
    x.rdy = rdy; x.rv = rv; x.rd = rd; x.ai = ai; x.ad = ad; x.rqv = rqv;
    x.ra = ra; x.fiv = fiv; x.fdv = fdv; x.fa = fa; x.fdat = fdat; x.bz = bz;
    return x;
  endfunction

  function automatic vec_t vrst();
    vec_t x;
    x = v(1, 32'h1234, 1, 32'h3050, 0, 1, 1, 64'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    x.rst = 1'b0;
    return x;
  endfunction

  // Driver: apply one vector and compare every output.
  task automatic apply(input vec_t x, input string tag);
    logic [229:0] act, exp;
    @(negedge clk);
    reset          = x.rst;
    i_miss_valid   = x.iv;
    i_miss_addr    = x.ia;
    d_miss_valid   = x.dv;
    d_miss_addr    = x.da;
    ext_flush      = x.fl;
    mem_req_ready  = x.rdy;
    mem_resp_valid = x.rv;
    mem_resp_data  = x.rd;
    #1;
    if (!x.rst) begin
      hi_a = '0; hi_d = '0; hd_a = '0; hd_d = '0;
    end
    if (x.fiv) begin hi_a = x.fa; hi_d = x.fdat; end
    if (x.fdv) begin hd_a = x.fa; hd_d = x.fdat; end
    exp = {x.ai, x.ad, x.rqv, x.ra, x.fiv, hi_a, hi_d, x.fdv, hd_a, hd_d, x.bz};
    act = {i_miss_ack, d_miss_ack, mem_req_valid, mem_req_addr,
           fetch_addr_valid, fetch_addr, fetched_data,
           d_fill_valid, d_fill_addr, d_fill_data, busy};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (ack_i,ack_d,rqv,ra,fiv,fia,fid,fdv,fda,fdd,busy)",
               tag, act, exp);
    end
  endtask

  // One full line with both requesters held high; grant owner is given.
  task automatic push_line(input bit own_d, input logic [31:0] base, input logic [63:0] d0);
    tbl.push_back(v(1, 32'h2008, 1, 32'h3050, 0, 0, 0, 0,
                    !own_d, own_d, 0, last_base, tail_i, tail_d, tail_a, tail_dat, 0));
    tbl.push_back(v(1, 32'h2008, 1, 32'h3050, 0, 1, 0, 0, 0, 0, 1, base, 0, 0, 0, 0, 1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(v(1, 32'h2008, 1, 32'h3050, 0, 0, 1, d0 + 64'(k), 0, 0, 0, base,
                      (k > 0) && !own_d, (k > 0) && own_d,
                      base + 32'(8 * (k - 1)), d0 + 64'(k - 1), 1));
    tail_i = !own_d; tail_d = own_d; tail_a = base + 32'd24; tail_dat = d0 + 64'd3;
    last_base = base;
  endtask

  initial begin
    hi_a = '0; hi_d = '0; hd_a = '0; hd_d = '0;
    last_base = '0; tail_i = 0; tail_d = 0; tail_a = '0; tail_dat = '0;
    reset = 1'b0; ext_flush = 0; i_miss_valid = 0; i_miss_addr = '0;
    d_miss_valid = 0; d_miss_addr = '0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0;
    repeat (3) @(posedge clk);

    // Reset state, with requests and beats present: everything must read 0.
    tbl.push_back(vrst());

    // Single I miss at 0x1234, ready at once, beats A0..A3.
    tbl.push_back(v(1, 32'h1234, 0, 0, 0, 0, 0, 0,     1, 0, 0, 32'h0,    0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0,            0, 0, 1, 32'h1220, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'hA0,       0, 0, 0, 32'h1220, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'hA1,       0, 0, 0, 32'h1220, 1, 0, 32'h1220, 64'hA0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'hA2,       0, 0, 0, 32'h1220, 1, 0, 32'h1228, 64'hA1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'hA3,       0, 0, 0, 32'h1220, 1, 0, 32'h1230, 64'hA2, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 32'h1220, 1, 0, 32'h1238, 64'hA3, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 32'h1220, 0, 0, 0, 0, 0));

    // Back to reset, then I and D tie: grants must go I, D, I, D.
    tbl.push_back(vrst());
    push_line(0, 32'h2000, 64'h100);
    push_line(1, 32'h3040, 64'h200);
    push_line(0, 32'h2000, 64'h300);
    push_line(1, 32'h3040, 64'h400);
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, last_base, tail_i, tail_d, tail_a, tail_dat, 0));

    // I line at 0x401C, flush with beat 2: beats 2-3 consumed without fills.
    tbl.push_back(v(1, 32'h401C, 0, 0, 0, 0, 0, 0,     1, 0, 0, 32'h3040, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0,            0, 0, 1, 32'h4000, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'hC0,       0, 0, 0, 32'h4000, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'hC1,       0, 0, 0, 32'h4000, 1, 0, 32'h4000, 64'hC0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 64'hC2,       0, 0, 0, 32'h4000, 1, 0, 32'h4008, 64'hC1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'hC3,       0, 0, 0, 32'h4000, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 32'h4000, 0, 0, 0, 0, 0));

    // D line at 0x5010 with flush toggling throughout: all four fills appear.
    tbl.push_back(v(0, 0, 1, 32'h5010, 1, 0, 0, 0,     0, 1, 0, 32'h4000, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 0, 0,            0, 0, 1, 32'h5000, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 64'hE0,       0, 0, 0, 32'h5000, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 64'hE1,       0, 0, 0, 32'h5000, 0, 1, 32'h5000, 64'hE0, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 64'hE2,       0, 0, 0, 32'h5000, 0, 1, 32'h5008, 64'hE1, 1));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 1, 64'hE3,       0, 0, 0, 32'h5000, 0, 1, 32'h5010, 64'hE2, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 32'h5000, 0, 1, 32'h5018, 64'hE3, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Memory not ready for 5 cycles: request held stable, no acks meanwhile.
    apply(v(1, 32'h6048, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h5000, 0, 0, 0, 0, 0), "stall_grant");
    for (int s = 0; s < 5; s++)
      apply(v(1, 32'h6048, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h6040, 0, 0, 0, 0, 1),
            $sformatf("stall_wait%0d", s));
    apply(v(1, 32'h6048, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h6040, 0, 0, 0, 0, 1), "stall_accept");
    for (int k = 0; k < 4; k++)
      apply(v(0, 0, 0, 0, 0, 0, 1, 64'hF0 + 64'(k), 0, 0, 0, 32'h6040,
              k > 0, 0, 32'h6040 + 32'(8 * (k - 1)), 64'hF0 + 64'(k - 1), 1),
            $sformatf("stall_beat%0d", k));
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h6040, 1, 0, 32'h6058, 64'hF3, 0), "stall_tail");

    // Flush in IDLE blocks the I grant for that cycle only.
    apply(v(1, 32'h7000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h6040, 0, 0, 0, 0, 0), "idle_flush");
    apply(v(1, 32'h7000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h6040, 0, 0, 0, 0, 0), "idle_grant");
    apply(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h7000, 0, 0, 0, 0, 1), "rst_req");
    apply(v(0, 0, 0, 0, 0, 0, 1, 64'h70, 0, 0, 0, 32'h7000, 0, 0, 0, 0, 1), "rst_beat0");
    apply(v(0, 0, 0, 0, 0, 0, 1, 64'h71, 0, 0, 0, 32'h7000, 1, 0, 32'h7000, 64'h70, 1), "rst_beat1");

    // Reset during beat 2: all outputs drop at once, stray beats ignored.
    begin
      vec_t x;
      x = v(0, 0, 0, 0, 0, 0, 1, 64'h72, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      x.rst = 1'b0;
      apply(x, "rst_mid_beat2");
    end
    apply(v(0, 0, 0, 0, 0, 0, 1, 64'h73, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_stray0");
    apply(v(0, 0, 0, 0, 0, 0, 1, 64'h74, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_stray1");

    // A fresh I miss after reset is served normally.
    apply(v(1, 32'h8010, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0), "post_grant");
    apply(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h8000, 0, 0, 0, 0, 1), "post_req");
    for (int k = 0; k < 4; k++)
      apply(v(0, 0, 0, 0, 0, 0, 1, 64'h80 + 64'(k), 0, 0, 0, 32'h8000,
              k > 0, 0, 32'h8000 + 32'(8 * (k - 1)), 64'h80 + 64'(k - 1), 1),
            $sformatf("post_beat%0d", k));
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8000, 1, 0, 32'h8018, 64'h83, 0), "post_tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
